postadder: RTL and testbench
============================

POSTADDER -- requirements
Module: postadder

Interface
REQ-001 SHALL have no parameters; widths are fixed for IEEE-754 single precision.
REQ-002 SHALL have ports: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have ports: rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: in_valid  input  1  operand present; in_ready  output  1  block can accept.
REQ-005 SHALL have ports: sign  input  1  result sign (sign_of_great from preadder); exp  input  8  common aligned exponent.
REQ-006 SHALL have ports: mantis  input  27  magnitude sum/difference of mantissas; bit26 carry, bit25 hidden, bits24:2 fraction, bit1 guard, bit0 round.
REQ-007 SHALL have ports: loss  input  1  sticky from alignment shift.
REQ-008 SHALL have ports: out_valid  output  1; out_ready  input  1; result  output  32  packed IEEE word.
REQ-009 SHALL have ports: overflow  output  1; underflow  output  1; both qualified by out_valid.

Function
REQ-010 SHALL implement FSM states IDLE, NORM, ROUND, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-011 IDLE: on in_valid=1 at an edge SHALL capture sign, exp, mantis, sticky=loss, clear flags, go to NORM.
REQ-012 NORM, mantis==0: SHALL set result={1'b0,31'b0} (+0), go to DONE, no flags.
REQ-013 NORM, exp==255 on entry: SHALL force result {sign,8'hFF,23'b0}, overflow=1, go to DONE.
REQ-014 NORM, bit26=1: SHALL shift right one bit, sticky|=bit0, exp+1, go to ROUND.
REQ-015 NORM, bit26=0, bit25=1: SHALL go to ROUND unchanged.
REQ-016 NORM, bit26:25=00, exp<=1: SHALL flush to {sign,31'b0}, underflow=1, go to DONE (no subnormals).
REQ-017 NORM, bit26:25=00, exp>1: SHALL shift left one bit (zero fill), exp-1, stay in NORM; exactly one shift per cycle.
REQ-018 ROUND: SHALL round to nearest even, inc = G & (R | S | L), with L=bit2, G=bit1, R=bit0, S=sticky.
REQ-019 ROUND: frac24 = bits25:2 + inc; on carry out of 24 bits SHALL set frac to 1.0 and exp+1.
REQ-020 ROUND: if final exp==255 SHALL output {sign,8'hFF,23'b0}, overflow=1; else {sign,exp,frac[22:0]}; go to DONE.
REQ-021 DONE: result/flags SHALL be held stable while out_ready=0; on out_ready=1 at an edge go to IDLE.
REQ-022 The block SHALL not accept in the same cycle it releases a result (no pass-through; next accept earliest one cycle after DONE exit).
REQ-023 Latency SHALL be 3 cycles accept-edge to out_valid for normalized or carry inputs, plus one cycle per left shift (max 3+25).
REQ-024 Input changes while not in IDLE SHALL have no effect.

Reset
REQ-025 rst=1 SHALL asynchronously force state IDLE, out_valid=0, in_ready=1, result=32'h0, overflow=0, underflow=0, internal registers 0.
REQ-026 Reset asserted mid-operation (NORM/ROUND/DONE) SHALL abandon the operation; no output of it SHALL appear after reset release.

Verification
REQ-027 1.0+1.0: exp=127, mantis=27'h4000000, loss=0 -> result=32'h40000000 on third cycle after accept, flags 0.
REQ-028 Cancellation: exp=127, mantis=27'h0000004 -> 23 left shifts, result=32'h34000000 after 26 cycles.
REQ-029 Rounding: mantis=27'h2000002, exp=127, loss=0 -> 32'h3F800000 (tie, even kept); mantis=27'h2000006 -> 32'h3F800002.
REQ-030 Overflow: sign=1, exp=254, mantis=27'h4000000 -> 32'hFF800000, overflow=1; zero: mantis=0 -> 32'h00000000.
REQ-031 Underflow: exp=1, mantis=27'h1000000 -> 32'h00000000 with sign 0, underflow=1.
REQ-032 Handshake/reset: hold out_ready=0 for 5 cycles -> result stable, in_ready=0; rst pulse during NORM -> out_valid stays 0, in_ready=1 immediately.

Source files
------------

// File: rtl/postadder.sv
// -----------------------------------------------------------------------------
// postadder
//   Back end of a single-precision floating-point adder. Takes the aligned
//   magnitude sum/difference produced by the pre-adder and turns it into a
//   packed IEEE-754 word. It normalizes one bit per cycle, rounds to nearest
//   even, and detects overflow to infinity and underflow (flush to zero; no
//   subnormal results are produced).
//
// Ports
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous active-high reset
//   in_valid   in   1   operand present
//   in_ready   out  1   block idle and able to accept an operand
//   sign       in   1   sign of the result
//   exp        in   8   common aligned exponent
//   mantis     in   27  [26] carry, [25] hidden, [24:2] fraction,
//                       [1] guard, [0] round
//   loss       in   1   sticky bit from the alignment shift
//   out_valid  out  1   result, overflow and underflow are valid
//   out_ready  in   1   consumer accepts the result
//   result     out  32  packed IEEE single-precision word
//   overflow   out  1   result saturated to infinity
//   underflow  out  1   result flushed to signed zero
// -----------------------------------------------------------------------------
module postadder (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        sign,
  input  logic [7:0]  exp,
  input  logic [26:0] mantis,
  input  logic        loss,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q,  state_d;
  logic        sign_q,   sign_d;
  logic [7:0]  exp_q,    exp_d;
  logic [26:0] mantis_q, mantis_d;
  logic        sticky_q, sticky_d;
  logic [31:0] result_q, result_d;
  logic        ovf_q,    ovf_d;
  logic        unf_q,    unf_d;

  // Rounding datapath, evaluated from the registered operand in ROUND.
  logic        rnd_inc;
  logic [24:0] frac_sum;
  logic [23:0] frac_rnd;
  logic [8:0]  exp_rnd;

  always_comb begin
    // Round to nearest, ties to even: L = bit2, G = bit1, R = bit0.
    rnd_inc  = mantis_q[1] & (mantis_q[0] | sticky_q | mantis_q[2]);
    frac_sum = {1'b0, mantis_q[25:2]} + {24'd0, rnd_inc};
    if (frac_sum[24]) begin
      // 1.111..1 + ulp = 10.000..0: renormalize to 1.0 and bump the exponent.
      frac_rnd = 24'h800000;
      exp_rnd  = {1'b0, exp_q} + 9'd1;
    end else begin
      frac_rnd = frac_sum[23:0];
      exp_rnd  = {1'b0, exp_q};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_q    <= 8'd0;
      mantis_q <= 27'd0;
      sticky_q <= 1'b0;
      result_q <= 32'h0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mantis_q <= mantis_d;
      sticky_q <= sticky_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mantis_d = mantis_q;
    sticky_d = sticky_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          sign_d   = sign;
          exp_d    = exp;
          mantis_d = mantis;
          sticky_d = loss;
          ovf_d    = 1'b0;
          unf_d    = 1'b0;
          state_d  = NORM;
        end
      end

      NORM: begin
        if (mantis_q == 27'd0) begin
          // Exact cancellation always yields +0 regardless of operand sign.
          result_d = 32'h0000_0000;
          state_d  = DONE;
        end else if (exp_q == 8'hFF) begin
          // Left shifts only lower the exponent, so 255 can only be seen
          // here on the first NORM cycle.
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
          state_d  = DONE;
        end else if (mantis_q[26]) begin
          mantis_d = {1'b0, mantis_q[26:1]};
          sticky_d = sticky_q | mantis_q[0];
          exp_d    = exp_q + 8'd1;
          state_d  = ROUND;
        end else if (mantis_q[25]) begin
          state_d  = ROUND;
        end else if (exp_q <= 8'd1) begin
          result_d = {sign_q, 31'd0};
          unf_d    = 1'b1;
          state_d  = DONE;
        end else begin
          // One normalization step per cycle.
          mantis_d = {mantis_q[25:0], 1'b0};
          exp_d    = exp_q - 8'd1;
        end
      end

      ROUND: begin
        // exp_rnd is 9 bits wide: 254 + carry-right-shift + rounding carry
        // reaches 256, which must still saturate rather than wrap.
        if (exp_rnd >= 9'd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
          ovf_d    = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], frac_rnd[22:0]};
        end
        exp_d   = exp_rnd[7:0];
        state_d = DONE;
      end

      DONE: begin
        // Return to IDLE only; a new operand is taken on a later edge.
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;

endmodule

// File: tb/tb_postadder.sv
// -----------------------------------------------------------------------------
// tb_postadder
//   Self-checking bench for postadder. A table of operand records with
//   expected result, flags and latency is applied in order; expectations are
//   pushed to a scoreboard queue on acceptance and popped by a monitor when
//   the result is handed off. Hand-written sequences cover back-pressure,
//   input changes while busy, and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_postadder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [7:0]  exp;
  logic [26:0] mantis;
  logic        loss;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        overflow;
  logic        underflow;

  postadder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp       (exp),
    .mantis    (mantis),
    .loss      (loss),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    string       name;
    logic        s;
    logic [7:0]  e;
    logic [26:0] m;
    logic        l;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
  } vec_t;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic        ovf;
    logic        unf;
    int          lat;
    int          acc_cyc;
  } sb_t;

  sb_t  sb[$];
  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic timeout_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: latency is counted from the cycle after the accept edge (=1)
  // to the first cycle out_valid is seen.
  bit seen = 0;
  int first_cyc = 0;
  always @(negedge clk) begin
    if (rst) begin
      seen = 0;
    end else if (out_valid) begin
      if (!seen) begin
        seen = 1;
        first_cyc = cyc;
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_output actual=%h required=none", result);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk({e.name, "_result"}, result, e.res);
          chk({e.name, "_ovf"}, {31'd0, overflow}, {31'd0, e.ovf});
          chk({e.name, "_unf"}, {31'd0, underflow}, {31'd0, e.unf});
          chk({e.name, "_lat"}, first_cyc - e.acc_cyc + 1, e.lat);
          chk({e.name, "_in_ready_busy"}, {31'd0, in_ready}, 32'd0);
          $display("xfer %s result=%h ovf=%0d unf=%0d lat=%0d",
                   e.name, result, overflow, underflow, first_cyc - e.acc_cyc + 1);
        end
        seen = 0;
      end
    end
  end

  task automatic send(input vec_t v, input bit push);
    int t;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) timeout_fail({v.name, "_wait_in_ready"});
    sign     = v.s;
    exp      = v.e;
    mantis   = v.m;
    loss     = v.l;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      sb_t e;
      e.name    = v.name;
      e.res     = v.res;
      e.ovf     = v.ovf;
      e.unf     = v.unf;
      e.lat     = v.lat;
      e.acc_cyc = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    if (sb.size() != 0) begin
      timeout_fail({name, "_drain"});
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "global timeout");
  end

  initial begin
    bit   any_out;
    int   t;
    vec_t junk;

    vecs[0]  = '{"one_plus_one", 1'b0, 8'd127, 27'h4000000, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[1]  = '{"cancel23",     1'b0, 8'd127, 27'h0000004, 1'b0, 32'h34000000, 1'b0, 1'b0, 26};
    vecs[2]  = '{"tie_even",     1'b0, 8'd127, 27'h2000002, 1'b0, 32'h3F800000, 1'b0, 1'b0, 3};
    vecs[3]  = '{"round_up",     1'b0, 8'd127, 27'h2000006, 1'b0, 32'h3F800002, 1'b0, 1'b0, 3};
    vecs[4]  = '{"ovf_carry",    1'b1, 8'd254, 27'h4000000, 1'b0, 32'hFF800000, 1'b1, 1'b0, 3};
    vecs[5]  = '{"zero",         1'b1, 8'd100, 27'h0000000, 1'b0, 32'h00000000, 1'b0, 1'b0, 2};
    vecs[6]  = '{"unf_exp1",     1'b0, 8'd1,   27'h1000000, 1'b0, 32'h00000000, 1'b0, 1'b1, 2};
    vecs[7]  = '{"exp255_in",    1'b0, 8'd255, 27'h2000000, 1'b0, 32'h7F800000, 1'b1, 1'b0, 2};
    vecs[8]  = '{"rnd_carry",    1'b0, 8'd127, 27'h3FFFFFE, 1'b0, 32'h40000000, 1'b0, 1'b0, 3};
    vecs[9]  = '{"sticky_tie",   1'b0, 8'd127, 27'h2000002, 1'b1, 32'h3F800001, 1'b0, 1'b0, 3};
    vecs[10] = '{"shift_gr",     1'b0, 8'd127, 27'h4000006, 1'b0, 32'h40000001, 1'b0, 1'b0, 3};
    vecs[11] = '{"shift_sticky", 1'b0, 8'd127, 27'h4000005, 1'b0, 32'h40000001, 1'b0, 1'b0, 3};
    vecs[12] = '{"unf_shift",    1'b1, 8'd3,   27'h0400000, 1'b0, 32'h80000000, 1'b0, 1'b1, 4};
    vecs[13] = '{"min_normal",   1'b0, 8'd3,   27'h0800000, 1'b0, 32'h00800000, 1'b0, 1'b0, 5};
    vecs[14] = '{"ovf_round",    1'b0, 8'd254, 27'h3FFFFFE, 1'b0, 32'h7F800000, 1'b1, 1'b0, 3};

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    sign      = 1'b0;
    exp       = 8'd0;
    mantis    = 27'd0;
    loss      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);
    chk("rst_unf", {31'd0, underflow}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table-driven vectors.
    for (int i = 0; i < 15; i++) begin
      send(vecs[i], 1'b1);
      drain(vecs[i].name);
    end

    // Back-pressure: result and flags held while out_ready is low.
    out_ready = 1'b0;
    send(vecs[0], 1'b1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    if (!out_valid) timeout_fail("hold_wait_valid");
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      chk("hold_result", result, 32'h40000000);
      chk("hold_out_valid", {31'd0, out_valid}, 32'd1);
      chk("hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    drain("hold");
    chk("hold_release_in_ready", {31'd0, in_ready}, 32'd1);

    // Inputs toggling while busy must not disturb the operation in flight.
    send(vecs[1], 1'b1);
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1;
      sign     = 1'b1;
      exp      = 8'd5;
      mantis   = 27'($urandom);
      loss     = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    drain("busy_inputs");

    // Reset during NORM abandons the operation.
    send(vecs[1], 1'b0);
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_result", result, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    any_out = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      if (out_valid) any_out = 1'b1;
    end
    chk("midrst_no_output", {31'd0, any_out}, 32'd0);
    chk("midrst_idle", {31'd0, in_ready}, 32'd1);

    // Normal operation resumes after the abandoned transaction.
    junk = vecs[3];
    junk.name = "after_rst";
    send(junk, 1'b1);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
